// File: rtl/red_target_tracker.sv
// Red-object tracker: classifies RGB444 pixels as red, accumulates a per-frame bounding box
// and count, and publishes the box centre once per frame with loss hysteresis.
module red_target_tracker #(
  parameter int R_MIN       = 8,
  parameter int GB_MAX      = 5,
  parameter int MIN_PIXELS  = 64,
  parameter int LOST_FRAMES = 3,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  input  logic [11:0]      pix_rgb,
  input  logic             frame_done,
  output logic [9:0]       aim_x,
  output logic [9:0]       aim_y,
  output logic             aim_detected,
  output logic [11:0]      box_x_min,
  output logic [11:0]      box_x_max,
  output logic [11:0]      box_y_min,
  output logic [11:0]      box_y_max,
  output logic [CNT_W-1:0] red_count,
  output logic             result_valid
);

  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [MISS_W-1:0] LOST_CNT = MISS_W'(LOST_FRAMES);
  localparam logic [3:0]        R_LIM    = 4'(R_MIN);
  localparam logic [3:0]        GB_LIM   = 4'(GB_MAX);

  typedef enum logic {ACCUM, COMMIT} state_t;
  state_t state_reg, state_next;
  logic   commit;

  logic [3:0] r_nib, g_nib, b_nib;
  logic       is_red;

  assign r_nib = pix_rgb[11:8];
  assign g_nib = pix_rgb[7:4];
  assign b_nib = pix_rgb[3:0];
  assign is_red = pix_valid && (r_nib >= R_LIM) && (g_nib <= GB_LIM) && (b_nib <= GB_LIM)
                  && (r_nib > g_nib) && (r_nib > b_nib);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ACCUM;
    else       state_reg <= state_next;
  end

  // frame_done is only acted on in ACCUM, so a pulse landing in COMMIT is dropped
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      ACCUM:   if (frame_done) state_next = COMMIT;
      COMMIT: begin
        commit     = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  logic [9:0]       xmin_reg, xmax_reg, ymin_reg, ymax_reg;
  logic [9:0]       xmin_base, xmax_base, ymin_base, ymax_base;
  logic [9:0]       xmin_next, xmax_next, ymin_next, ymax_next;
  logic [CNT_W-1:0] cnt_reg, cnt_base, cnt_next;

  // During COMMIT the merge starts from the init values, so a red pixel in that cycle
  // lands in the next frame instead of being lost
  always_comb begin
    xmin_base = commit ? 10'h3FF : xmin_reg;
    ymin_base = commit ? 10'h3FF : ymin_reg;
    xmax_base = commit ? 10'h000 : xmax_reg;
    ymax_base = commit ? 10'h000 : ymax_reg;
    cnt_base  = commit ? '0 : cnt_reg;
    xmin_next = xmin_base;
    ymin_next = ymin_base;
    xmax_next = xmax_base;
    ymax_next = ymax_base;
    cnt_next  = cnt_base;
    if (is_red) begin
      if (x_pixel < xmin_base) xmin_next = x_pixel;
      if (x_pixel > xmax_base) xmax_next = x_pixel;
      if (y_pixel < ymin_base) ymin_next = y_pixel;
      if (y_pixel > ymax_base) ymax_next = y_pixel;
      if (cnt_base != '1)      cnt_next  = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xmin_reg <= 10'h3FF;
      ymin_reg <= 10'h3FF;
      xmax_reg <= 10'h000;
      ymax_reg <= 10'h000;
      cnt_reg  <= '0;
    end else begin
      xmin_reg <= xmin_next;
      ymin_reg <= ymin_next;
      xmax_reg <= xmax_next;
      ymax_reg <= ymax_next;
      cnt_reg  <= cnt_next;
    end
  end

  logic [10:0]       sum_x, sum_y;
  logic [MISS_W-1:0] miss_cnt_reg, miss_inc;
  logic              hit;

  assign sum_x    = {1'b0, xmin_reg} + {1'b0, xmax_reg};
  assign sum_y    = {1'b0, ymin_reg} + {1'b0, ymax_reg};
  assign hit      = (cnt_reg >= MIN_CNT);
  assign miss_inc = (miss_cnt_reg == LOST_CNT) ? miss_cnt_reg : miss_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      aim_x        <= 10'd320;
      aim_y        <= 10'd240;
      box_x_min    <= '0;
      box_x_max    <= '0;
      box_y_min    <= '0;
      box_y_max    <= '0;
      aim_detected <= 1'b0;
      red_count    <= '0;
      result_valid <= 1'b0;
      miss_cnt_reg <= '0;
    end else begin
      result_valid <= commit;
      if (commit) begin
        red_count <= cnt_reg;
        if (hit) begin
          box_x_min    <= {2'b00, xmin_reg};
          box_x_max    <= {2'b00, xmax_reg};
          box_y_min    <= {2'b00, ymin_reg};
          box_y_max    <= {2'b00, ymax_reg};
          aim_x        <= sum_x[10:1];
          aim_y        <= sum_y[10:1];
          aim_detected <= 1'b1;
          miss_cnt_reg <= '0;
        end else begin
          miss_cnt_reg <= miss_inc;
          if (miss_inc == LOST_CNT) aim_detected <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_red_target_tracker.sv
// Directed bench for red_target_tracker: a default instance and a MIN_PIXELS=1 instance
// share one pixel stream; each scenario task checks its own expected results inline.
module tb_red_target_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [9:0]  x_pixel, y_pixel;
  logic [11:0] pix_rgb;
  logic        frame_done;

  logic [9:0]  aim_x, aim_y, aim_x_1, aim_y_1;
  logic        aim_detected, aim_detected_1, result_valid, result_valid_1;
  logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [11:0] box_x_min_1, box_x_max_1, box_y_min_1, box_y_max_1;
  logic [16:0] red_count, red_count_1;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  red_target_tracker dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max), .red_count(red_count),
    .result_valid(result_valid)
  );

  red_target_tracker #(.MIN_PIXELS(1)) dut1 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .aim_x(aim_x_1), .aim_y(aim_y_1),
    .aim_detected(aim_detected_1), .box_x_min(box_x_min_1), .box_x_max(box_x_max_1),
    .box_y_min(box_y_min_1), .box_y_max(box_y_max_1), .red_count(red_count_1),
    .result_valid(result_valid_1)
  );

  task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y,
                       input logic [11:0] rgb, input logic fd);
    @(negedge clk);
    pix_valid  = v;
    x_pixel    = x;
    y_pixel    = y;
    pix_rgb    = rgb;
    frame_done = fd;
  endtask

  // First pixel uses the weakest colour that still classifies as red
  task automatic red_block(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        drive(1'b1, 10'(x), 10'(y), (x == x0 && y == y0) ? 12'h855 : 12'hF00, 1'b0);
  endtask

  // Optional red pixel alongside frame_done; optional red pixel plus a stray frame_done in COMMIT
  task automatic end_frame(input logic red_fd, input logic [9:0] fx, input logic [9:0] fy,
                           input logic extra, input logic [9:0] cx, input logic [9:0] cy);
    drive(red_fd, fx, fy, 12'hF00, 1'b1);
    drive(extra, cx, cy, 12'hF00, extra);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rv_early: got %b need 0", result_valid);
    end
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    checks++;
    if ({result_valid, result_valid_1} !== 2'b11) begin
      errors++;
      $display("FAIL rv_pulse: got %b need 11", {result_valid, result_valid_1});
    end
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rv_width: got %b need 0", result_valid);
    end
    frame_no++;
    $display("frame %0d: red_count=%0d det=%b aim=(%0d,%0d) box=(%0d,%0d,%0d,%0d) | min1: det=%b aim=(%0d,%0d)",
             frame_no, red_count, aim_detected, aim_x, aim_y, box_x_min, box_x_max,
             box_y_min, box_y_max, aim_detected_1, aim_x_1, aim_y_1);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    pix_valid = 1'b0; frame_done = 1'b0; x_pixel = '0; y_pixel = '0; pix_rgb = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({aim_x, aim_y} !== {10'd320, 10'd240}) begin
      errors++;
      $display("FAIL reset_aim: got (%0d,%0d) need (320,240)", aim_x, aim_y);
    end
    checks++;
    if ({box_x_min, box_x_max, box_y_min, box_y_max, aim_detected, result_valid, red_count} !== '0) begin
      errors++;
      $display("FAIL reset_zero: box=(%0d,%0d,%0d,%0d) det=%b rv=%b cnt=%0d need all 0",
               box_x_min, box_x_max, box_y_min, box_y_max, aim_detected, result_valid, red_count);
    end
    reset = 1'b0;
    // near-miss colours and a red colour without pix_valid
    drive(1'b1, 10'd10, 10'd10, 12'h755, 1'b0);
    drive(1'b1, 10'd11, 10'd10, 12'hF60, 1'b0);
    drive(1'b1, 10'd12, 10'd10, 12'hF06, 1'b0);
    drive(1'b1, 10'd13, 10'd10, 12'h444, 1'b0);
    drive(1'b0, 10'd14, 10'd10, 12'hF00, 1'b0);
    end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    checks++;
    if ({aim_detected, aim_x, aim_y, red_count} !== {1'b0, 10'd320, 10'd240, 17'd0}) begin
      errors++;
      $display("FAIL empty_frame: got det=%b aim=(%0d,%0d) cnt=%0d need det=0 aim=(320,240) cnt=0",
               aim_detected, aim_x, aim_y, red_count);
    end
  endtask

  task automatic test_block;
    drive(1'b1, 10'd99, 10'd49, 12'h755, 1'b0);
    red_block(100, 139, 50, 69);
    drive(1'b1, 10'd140, 10'd70, 12'hF60, 1'b0);
    end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    checks++;
    if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {12'd100, 12'd139, 12'd50, 12'd69}) begin
      errors++;
      $display("FAIL block_box: got (%0d,%0d,%0d,%0d) need (100,139,50,69)",
               box_x_min, box_x_max, box_y_min, box_y_max);
    end
    checks++;
    if ({aim_x, aim_y, aim_detected, red_count} !== {10'd119, 10'd59, 1'b1, 17'd800}) begin
      errors++;
      $display("FAIL block_aim: got aim=(%0d,%0d) det=%b cnt=%0d need (119,59) det=1 cnt=800",
               aim_x, aim_y, aim_detected, red_count);
    end
  endtask

  task automatic test_corner;
    drive(1'b1, 10'd639, 10'd479, 12'hF00, 1'b0);
    end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    checks++;
    if ({box_x_min_1, box_x_max_1, box_y_min_1, box_y_max_1} !== {12'd639, 12'd639, 12'd479, 12'd479}) begin
      errors++;
      $display("FAIL corner_box: got (%0d,%0d,%0d,%0d) need (639,639,479,479)",
               box_x_min_1, box_x_max_1, box_y_min_1, box_y_max_1);
    end
    checks++;
    if ({aim_x_1, aim_y_1, aim_detected_1, red_count_1} !== {10'd639, 10'd479, 1'b1, 17'd1}) begin
      errors++;
      $display("FAIL corner_aim: got aim=(%0d,%0d) det=%b cnt=%0d need (639,479) det=1 cnt=1",
               aim_x_1, aim_y_1, aim_detected_1, red_count_1);
    end
    // below MIN_PIXELS on the default instance: box and aim hold, count still updates
    checks++;
    if ({aim_x, aim_y, box_x_max, aim_detected, red_count} !== {10'd119, 10'd59, 12'd139, 1'b1, 17'd1}) begin
      errors++;
      $display("FAIL corner_miss: got aim=(%0d,%0d) xmax=%0d det=%b cnt=%0d need (119,59) 139 det=1 cnt=1",
               aim_x, aim_y, box_x_max, aim_detected, red_count);
    end
  endtask

  task automatic test_loss;
    logic exp_det;
    red_block(200, 207, 300, 307);
    end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    checks++;
    if ({aim_x, aim_y, aim_detected, red_count} !== {10'd203, 10'd303, 1'b1, 17'd64}) begin
      errors++;
      $display("FAIL loss_hit: got aim=(%0d,%0d) det=%b cnt=%0d need (203,303) det=1 cnt=64",
               aim_x, aim_y, aim_detected, red_count);
    end
    for (int i = 1; i <= 4; i++) begin
      end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
      exp_det = (i < 3);
      checks++;
      if ({aim_detected, aim_x, aim_y, red_count} !== {exp_det, 10'd203, 10'd303, 17'd0}) begin
        errors++;
        $display("FAIL loss_empty%0d: got det=%b aim=(%0d,%0d) cnt=%0d need det=%b aim=(203,303) cnt=0",
                 i, aim_detected, aim_x, aim_y, red_count, exp_det);
      end
    end
  endtask

  task automatic test_back_to_back;
    red_block(10, 17, 20, 26);
    red_block(10, 16, 27, 27);
    // 64th pixel rides on frame_done; (5,5) plus a stray frame_done land in COMMIT
    end_frame(1'b1, 10'd17, 10'd27, 1'b1, 10'd5, 10'd5);
    checks++;
    if ({red_count, aim_detected, aim_x, aim_y} !== {17'd64, 1'b1, 10'd13, 10'd23}) begin
      errors++;
      $display("FAIL coinc_frame: got cnt=%0d det=%b aim=(%0d,%0d) need cnt=64 det=1 aim=(13,23)",
               red_count, aim_detected, aim_x, aim_y);
    end
    checks++;
    if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {12'd10, 12'd17, 12'd20, 12'd27}) begin
      errors++;
      $display("FAIL coinc_box: got (%0d,%0d,%0d,%0d) need (10,17,20,27)",
               box_x_min, box_x_max, box_y_min, box_y_max);
    end
    end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    checks++;
    if ({red_count, red_count_1} !== {17'd1, 17'd1}) begin
      errors++;
      $display("FAIL commit_pix_cnt: got %0d/%0d need 1/1", red_count, red_count_1);
    end
    checks++;
    if ({box_x_min_1, box_x_max_1, box_y_min_1, box_y_max_1, aim_x_1, aim_y_1} !==
        {12'd5, 12'd5, 12'd5, 12'd5, 10'd5, 10'd5}) begin
      errors++;
      $display("FAIL commit_pix_box: got box=(%0d,%0d,%0d,%0d) aim=(%0d,%0d) need all 5",
               box_x_min_1, box_x_max_1, box_y_min_1, box_y_max_1, aim_x_1, aim_y_1);
    end
  endtask

  task automatic test_reset_mid;
    red_block(0, 499, 100, 100);
    @(negedge clk);
    reset = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({red_count, aim_detected, aim_x, aim_y, result_valid} !== {17'd0, 1'b0, 10'd320, 10'd240, 1'b0}) begin
      errors++;
      $display("FAIL midreset_out: got cnt=%0d det=%b aim=(%0d,%0d) rv=%b need 0 0 (320,240) 0",
               red_count, aim_detected, aim_x, aim_y, result_valid);
    end
    red_block(0, 99, 200, 200);
    end_frame(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    checks++;
    if ({red_count, aim_detected, aim_x, aim_y} !== {17'd100, 1'b1, 10'd49, 10'd200}) begin
      errors++;
      $display("FAIL midreset_frame: got cnt=%0d det=%b aim=(%0d,%0d) need cnt=100 det=1 aim=(49,200)",
               red_count, aim_detected, aim_x, aim_y);
    end
    checks++;
    if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {12'd0, 12'd99, 12'd200, 12'd200}) begin
      errors++;
      $display("FAIL midreset_box: got (%0d,%0d,%0d,%0d) need (0,99,200,200)",
               box_x_min, box_x_max, box_y_min, box_y_max);
    end
  endtask

  initial begin
    reset = 1'b1;
    pix_valid = 1'b0;
    frame_done = 1'b0;
    x_pixel = '0;
    y_pixel = '0;
    pix_rgb = '0;
    test_reset();
    test_block();
    test_corner();
    test_loss();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
